// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and the slave/master FSM state encodings.
package axi4_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE    = 2'd0,
    W_WAIT_W  = 2'd1,
    W_WAIT_AW = 2'd2,
    W_RESP    = 2'd3
  } wstate_e;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rstate_e;

endpackage

// File: rtl/axi4_lite_regfile.sv
// NUM_REGS x DATA_WIDTH storage with a byte-strobed synchronous write port and an
// asynchronous read port; reset clears every register and suppresses the write.
module axi4_lite_regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 8,
  parameter int IDX_W      = $clog2(NUM_REGS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [IDX_W-1:0]        widx,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic [IDX_W-1:0]        ridx,
  output logic [DATA_WIDTH-1:0]   rdata
);

  logic [DATA_WIDTH-1:0] mem_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] mem_d [NUM_REGS];

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      for (int b = 0; b < DATA_WIDTH / 8; b++) begin
        if (wstrb[b]) begin
          mem_d[widx][b*8 +: 8] = wdata[b*8 +: 8];
        end else begin
          mem_d[widx][b*8 +: 8] = mem_q[widx][b*8 +: 8];
        end
      end
    end else begin
      mem_d = mem_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_q[i] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q[ridx];

endmodule

// File: rtl/axi4_lite_slave_regs.sv
// AXI4-Lite slave terminating reads and writes into a small register file, with
// independent read and write FSMs and registered responses.
module axi4_lite_slave_regs
  import axi4_lite_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_REGS      = 8
) (
  input  logic                     ACLK,
  input  logic                     ARESET,
  input  logic [ADDRESS_WIDTH-1:0] S_AXI_AWADDR,
  input  logic                     S_AXI_AWVALID,
  output logic                     S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]    S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0]  S_AXI_WSTRB,
  input  logic                     S_AXI_WVALID,
  output logic                     S_AXI_WREADY,
  output logic [1:0]               S_AXI_BRESP,
  output logic                     S_AXI_BVALID,
  input  logic                     S_AXI_BREADY,
  input  logic [ADDRESS_WIDTH-1:0] S_AXI_ARADDR,
  input  logic                     S_AXI_ARVALID,
  output logic                     S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]    S_AXI_RDATA,
  output logic [1:0]               S_AXI_RRESP,
  output logic                     S_AXI_RVALID,
  input  logic                     S_AXI_RREADY
);

  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int IDX_W    = $clog2(NUM_REGS);

  function automatic logic addr_ok(input logic [ADDRESS_WIDTH-1:0] a);
    return (a >> (ADDR_LSB + IDX_W)) == {ADDRESS_WIDTH{1'b0}};
  endfunction

  wstate_e wstate_q, wstate_d;
  rstate_e rstate_q, rstate_d;

  // live_q keeps every READY low through reset and for the reset edge itself.
  logic                     live_q, live_d;
  logic [ADDRESS_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic [STRB_W-1:0]        wstrb_q, wstrb_d;
  logic [1:0]               bresp_q, bresp_d;
  logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;
  logic [1:0]               rresp_q, rresp_d;

  logic                     awready, wready, arready;
  logic                     aw_hs, w_hs, ar_hs;
  logic                     cm_go;
  logic [ADDRESS_WIDTH-1:0] cm_addr;
  logic [DATA_WIDTH-1:0]    cm_data;
  logic [STRB_W-1:0]        cm_strb;
  logic [DATA_WIDTH-1:0]    rf_rdata;

  assign awready = live_q && ((wstate_q == W_IDLE) || (wstate_q == W_WAIT_AW));
  assign wready  = live_q && ((wstate_q == W_IDLE) || (wstate_q == W_WAIT_W));
  assign arready = live_q && (rstate_q == R_IDLE);
  assign aw_hs   = S_AXI_AWVALID && awready;
  assign w_hs    = S_AXI_WVALID && wready;
  assign ar_hs   = S_AXI_ARVALID && arready;

  always_comb begin
    live_d   = 1'b1;
    wstate_d = wstate_q;
    cm_go    = 1'b0;
    if (aw_hs) begin
      awaddr_d = S_AXI_AWADDR;
    end else begin
      awaddr_d = awaddr_q;
    end
    if (w_hs) begin
      wdata_d = S_AXI_WDATA;
      wstrb_d = S_AXI_WSTRB;
    end else begin
      wdata_d = wdata_q;
      wstrb_d = wstrb_q;
    end
    // Commit operands come from whichever side handshakes now, else from the latch.
    cm_addr = awaddr_d;
    cm_data = wdata_d;
    cm_strb = wstrb_d;
    case (wstate_q)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          wstate_d = W_RESP;
          cm_go    = 1'b1;
        end else if (aw_hs) begin
          wstate_d = W_WAIT_W;
        end else if (w_hs) begin
          wstate_d = W_WAIT_AW;
        end else begin
          wstate_d = W_IDLE;
        end
      end
      W_WAIT_W: begin
        if (w_hs) begin
          wstate_d = W_RESP;
          cm_go    = 1'b1;
        end else begin
          wstate_d = W_WAIT_W;
        end
      end
      W_WAIT_AW: begin
        if (aw_hs) begin
          wstate_d = W_RESP;
          cm_go    = 1'b1;
        end else begin
          wstate_d = W_WAIT_AW;
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) begin
          wstate_d = W_IDLE;
        end else begin
          wstate_d = W_RESP;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
    if (cm_go) begin
      bresp_d = addr_ok(cm_addr) ? RESP_OKAY : RESP_SLVERR;
    end else begin
      bresp_d = bresp_q;
    end
  end

  always_comb begin
    rstate_d = rstate_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    case (rstate_q)
      R_IDLE: begin
        if (ar_hs) begin
          rstate_d = R_DATA;
          rdata_d  = addr_ok(S_AXI_ARADDR) ? rf_rdata : {DATA_WIDTH{1'b0}};
          rresp_d  = addr_ok(S_AXI_ARADDR) ? RESP_OKAY : RESP_SLVERR;
        end else begin
          rstate_d = R_IDLE;
        end
      end
      R_DATA: begin
        if (S_AXI_RREADY) begin
          rstate_d = R_IDLE;
        end else begin
          rstate_d = R_DATA;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      live_q   <= 1'b0;
      wstate_q <= W_IDLE;
      rstate_q <= R_IDLE;
      awaddr_q <= {ADDRESS_WIDTH{1'b0}};
      wdata_q  <= {DATA_WIDTH{1'b0}};
      wstrb_q  <= {STRB_W{1'b0}};
      bresp_q  <= 2'b00;
      rdata_q  <= {DATA_WIDTH{1'b0}};
      rresp_q  <= 2'b00;
    end else begin
      live_q   <= live_d;
      wstate_q <= wstate_d;
      rstate_q <= rstate_d;
      awaddr_q <= awaddr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      bresp_q  <= bresp_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
    end
  end

  axi4_lite_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .IDX_W      (IDX_W)
  ) u_regfile (
    .clk   (ACLK),
    .rst   (ARESET),
    .we    (cm_go && addr_ok(cm_addr)),
    .widx  (cm_addr[ADDR_LSB +: IDX_W]),
    .wdata (cm_data),
    .wstrb (cm_strb),
    .ridx  (S_AXI_ARADDR[ADDR_LSB +: IDX_W]),
    .rdata (rf_rdata)
  );

  assign S_AXI_AWREADY = awready;
  assign S_AXI_WREADY  = wready;
  assign S_AXI_ARREADY = arready;
  assign S_AXI_BVALID  = (wstate_q == W_RESP);
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_RVALID  = (rstate_q == R_DATA);
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;

endmodule

// File: tb/tb_axi4_lite_slave_regs.sv
// Directed bench for axi4_lite_slave_regs: inputs change and outputs are checked on
// the falling edge, with hand-computed expectations.
module tb_axi4_lite_slave_regs;

  logic        clk = 1'b0;
  logic        areset;
  logic [31:0] awaddr, wdata, araddr;
  logic [3:0]  wstrb;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;

  int tests_run = 0;
  int tests_failed = 0;
  logic [31:0] rd_val;
  logic [1:0]  rd_resp;

  always #5 clk = ~clk;

  axi4_lite_slave_regs #(
    .ADDRESS_WIDTH (32),
    .DATA_WIDTH    (32),
    .NUM_REGS      (8)
  ) dut (
    .ACLK          (clk),
    .ARESET        (areset),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // AW and W presented together; checks the response and its retirement.
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                    input logic [1:0] exp_resp, input string tag);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    check({tag, "_bvalid"}, 64'(bvalid), 64'd1);
    check({tag, "_bresp"}, 64'(bresp), 64'(exp_resp));
    bready = 1'b1;
    step();
    bready = 1'b0;
    check({tag, "_bdone"}, 64'(bvalid), 64'd0);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
    araddr = a; arvalid = 1'b1;
    step();
    arvalid = 1'b0;
    d = rdata; r = rresp;
    check("rd_rvalid", 64'(rvalid), 64'd1);
    rready = 1'b1;
    step();
    rready = 1'b0;
  endtask

  initial begin
    areset = 1'b1;
    awaddr = 32'h0; wdata = 32'h0; wstrb = 4'h0; araddr = 32'h0;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    @(negedge clk);
    step();
    check("rst_awready", 64'(awready), 64'd0);
    check("rst_wready", 64'(wready), 64'd0);
    check("rst_arready", 64'(arready), 64'd0);
    check("rst_valids", 64'({bvalid, rvalid}), 64'd0);
    check("rst_rdata", 64'(rdata), 64'd0);
    areset = 1'b0;
    step();
    check("post_rst_readys", 64'({awready, wready, arready}), 64'h7);

    // Simultaneous AW/W write, then read back (sub-word address bits ignored).
    wr(32'h4, 32'hDEADBEEF, 4'hF, 2'b00, "wr4");
    rd(32'h4, rd_val, rd_resp);
    check("rd4_data", 64'(rd_val), 64'hDEADBEEF);
    check("rd4_resp", 64'(rd_resp), 64'd0);
    rd(32'h6, rd_val, rd_resp);
    check("rd6_alias", 64'(rd_val), 64'hDEADBEEF);

    // W before AW with partial strobes over all-ones.
    wr(32'h8, 32'hFFFFFFFF, 4'hF, 2'b00, "wr8_ones");
    wdata = 32'h11223344; wstrb = 4'b0101; wvalid = 1'b1;
    step();
    wvalid = 1'b0;
    check("wfirst_bvalid", 64'(bvalid), 64'd0);
    check("wfirst_readys", 64'({awready, wready}), 64'b10);
    awaddr = 32'h8; awvalid = 1'b1;
    step();
    awvalid = 1'b0;
    check("wfirst_bvalid_after_aw", 64'(bvalid), 64'd1);
    check("wfirst_bresp", 64'(bresp), 64'd0);
    bready = 1'b1;
    step();
    bready = 1'b0;
    rd(32'h8, rd_val, rd_resp);
    check("rd8_strobed", 64'(rd_val), 64'hFF22FF44);

    // Out-of-range write and read; zero-strobe write.
    wr(32'h20, 32'h12345678, 4'hF, 2'b10, "wr20_oor");
    rd(32'h20, rd_val, rd_resp);
    check("rd20_data", 64'(rd_val), 64'd0);
    check("rd20_resp", 64'(rd_resp), 64'h2);
    rd(32'h0, rd_val, rd_resp);
    check("rd0_untouched", 64'(rd_val), 64'd0);
    wr(32'h4, 32'h00000000, 4'h0, 2'b00, "wr4_nostrb");
    rd(32'h4, rd_val, rd_resp);
    check("rd4_after_nostrb", 64'(rd_val), 64'hDEADBEEF);

    // Back-pressure on both channels for 5 cycles, with a second AR waiting.
    araddr = 32'h4; arvalid = 1'b1;
    awaddr = 32'hC; wdata = 32'h0BADF00D; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 32'h8;
    for (int i = 0; i < 5; i++) begin
      check("stall_rvalid", 64'(rvalid), 64'd1);
      check("stall_rdata", 64'(rdata), 64'hDEADBEEF);
      check("stall_arready", 64'(arready), 64'd0);
      check("stall_bvalid", 64'(bvalid), 64'd1);
      check("stall_bresp", 64'(bresp), 64'd0);
      step();
    end
    rready = 1'b1; bready = 1'b1;
    step();
    rready = 1'b0; bready = 1'b0;
    check("stall_release_valids", 64'({rvalid, bvalid}), 64'd0);
    check("stall_release_arready", 64'(arready), 64'd1);
    step();
    arvalid = 1'b0;
    check("queued_ar_rvalid", 64'(rvalid), 64'd1);
    check("queued_ar_rdata", 64'(rdata), 64'hFF22FF44);
    rready = 1'b1;
    step();
    rready = 1'b0;
    rd(32'hC, rd_val, rd_resp);
    check("rdC_data", 64'(rd_val), 64'h0BADF00D);

    // Same-edge read and write commit to index 0.
    araddr = 32'h0; arvalid = 1'b1;
    awaddr = 32'h0; wdata = 32'hA5A5A5A5; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    step();
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    check("coll_rdata_old", 64'(rdata), 64'd0);
    check("coll_bvalid", 64'(bvalid), 64'd1);
    rready = 1'b1; bready = 1'b1;
    step();
    rready = 1'b0; bready = 1'b0;
    rd(32'h0, rd_val, rd_resp);
    check("coll_rdata_new", 64'(rd_val), 64'hA5A5A5A5);

    // Reset with the write FSM waiting for W and a read pending.
    awaddr = 32'h4; awvalid = 1'b1; araddr = 32'h4; arvalid = 1'b1;
    step();
    awvalid = 1'b0; arvalid = 1'b0;
    check("pre_rst_waitw", 64'({awready, wready}), 64'b01);
    check("pre_rst_rvalid", 64'(rvalid), 64'd1);
    wdata = 32'h99999999; wstrb = 4'hF; wvalid = 1'b1; areset = 1'b1;
    step();
    wvalid = 1'b0;
    check("midrst_valids", 64'({bvalid, rvalid}), 64'd0);
    check("midrst_readys", 64'({awready, wready, arready}), 64'd0);
    check("midrst_rdata", 64'(rdata), 64'd0);
    areset = 1'b0;
    step();
    check("midrst_readys_back", 64'({awready, wready, arready}), 64'h7);
    rd(32'h4, rd_val, rd_resp);
    check("midrst_reg4_cleared", 64'(rd_val), 64'd0);
    rd(32'h0, rd_val, rd_resp);
    check("midrst_reg0_cleared", 64'(rd_val), 64'd0);
    rd(32'h8, rd_val, rd_resp);
    check("midrst_reg8_cleared", 64'(rd_val), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/axi4_lite_slave_regs.md
# axi4_lite_slave_regs

AXI4-Lite slave endpoint with a memory-mapped register file; sits directly downstream of `axi4_lite_master` and terminates its read and write transactions. Independent read and write FSMs accept address/data handshakes, apply byte strobes, and return OKAY or SLVERR responses. Register contents are reachable only through the bus.

## Interface
- `ADDRESS_WIDTH`, 32, AXI address width
- `DATA_WIDTH`, 32, data width; must be 32 or 64
- `NUM_REGS`, 8, number of DATA_WIDTH registers; power of two, ≥2

- `ACLK`  in  1  single clock, all logic on rising edge
- `ARESET`  in  1  synchronous, active-high reset
- `S_AXI_AWADDR`  in  ADDRESS_WIDTH  write address
- `S_AXI_AWVALID`  in  1  write address valid
- `S_AXI_AWREADY`  out  1  write address ready
- `S_AXI_WDATA`  in  DATA_WIDTH  write data
- `S_AXI_WSTRB`  in  DATA_WIDTH/8  byte strobes
- `S_AXI_WVALID`  in  1  write data valid
- `S_AXI_WREADY`  out  1  write data ready
- `S_AXI_BRESP`  out  2  write response
- `S_AXI_BVALID`  out  1  write response valid
- `S_AXI_BREADY`  in  1  write response ready
- `S_AXI_ARADDR`  in  ADDRESS_WIDTH  read address
- `S_AXI_ARVALID`  in  1  read address valid
- `S_AXI_ARREADY`  out  1  read address ready
- `S_AXI_RDATA`  out  DATA_WIDTH  read data
- `S_AXI_RRESP`  out  2  read response
- `S_AXI_RVALID`  out  1  read data valid
- `S_AXI_RREADY`  in  1  read data ready

## Operation
- Decode: ADDR_LSB = log2(DATA_WIDTH/8); index = addr[ADDR_LSB +: log2(NUM_REGS)]; addr bits below ADDR_LSB ignored. Address ≥ NUM_REGS·DATA_WIDTH/8 is out of range.
- Responses: OKAY = 2'b00, SLVERR = 2'b10.
- Write FSM: W_IDLE → W_WAIT_W (AW taken, W not), W_WAIT_AW (W taken, AW not), or W_RESP (both in same cycle). W_WAIT_W/W_WAIT_AW → W_RESP on the missing handshake. W_RESP → W_IDLE on BVALID&&BREADY.
- AWREADY = 1 in W_IDLE and W_WAIT_AW; WREADY = 1 in W_IDLE and W_WAIT_W; BVALID = 1 only in W_RESP. Address/data/strobe latched at their own handshake.
- Commit: on the edge entering W_RESP, byte lanes with WSTRB[i]=1 updated, others kept. Out-of-range: no register changes, BRESP = SLVERR. WSTRB = 0: no change, BRESP = OKAY.
- Read FSM: R_IDLE (ARREADY = 1) → R_DATA on ARVALID&&ARREADY; R_DATA (RVALID = 1) → R_IDLE on RVALID&&RREADY. RDATA/RRESP registered at the AR handshake edge; out of range gives RDATA = 0, RRESP = SLVERR.
- Read and write paths are fully independent; both may be active at once.
- RDATA, RRESP, and BRESP are held stable while VALID is high and READY is low.

## Timing
- Reset (ARESET high at an edge): all registers = 0; both FSMs idle. Every output is 0 while in reset, including the READY signals.
- First edge with ARESET low: AWREADY, WREADY, and ARREADY are 1.
- Reset mid-transaction: the transaction is abandoned, and no write commits on a reset edge. VALID is 0 in the cycle after the reset edge.
- Read latency: AR handshake at edge N → RVALID = 1 after edge N, so data is available in the next cycle. Throughput is at most one read per 2 cycles with RREADY held high.
- Write latency: last of the AW/W handshakes at edge N → BVALID = 1 after edge N, with the register already updated.
- Same-edge collision: an AR handshake and a write commit to the same index on the same edge → read returns the pre-write value. A later read returns the new value.
- No combinational path from any input to any output; all outputs come from registers or decode of FSM state.

## Structure
- Package `axi4_lite_pkg`: RESP_OKAY and RESP_SLVERR constants, and the write/read FSM state encodings. Shared with `axi4_lite_master`.
- Sub-module `axi4_lite_regfile`: NUM_REGS × DATA_WIDTH storage. It has a synchronous byte-strobed write port (we, widx, wdata, wstrb), an asynchronous read port (ridx → rdata), and synchronous reset to 0.
- Top module holds both FSMs, the latches, and the address decode.

## Test plan
- Reset, then write 0xDEADBEEF to 0x4 with WSTRB = 4'hF, AW and W in the same cycle → BVALID next cycle with BRESP = 00. A read of 0x4 returns 0xDEADBEEF, RRESP = 00.
- W one cycle before AW, then AW → BVALID one cycle after AW. Write 0x11223344 to 0x8 with WSTRB = 4'b0101 over a prior 0xFFFFFFFF → a read returns 0xFF22FF44.
- Write to 0x20 (NUM_REGS = 8) → BRESP = 10 and registers unchanged. A read of 0x20 → RDATA = 0, RRESP = 10.
- Hold RREADY and BREADY low for 5 cycles → RVALID/BVALID and data stay stable. No new AR is accepted (ARREADY = 0) until the pending read completes.
- Same-edge AR and write commit to 0x0 (old value 0, new value 0xA5A5A5A5) → read returns 0. A following read returns 0xA5A5A5A5.
- Assert ARESET while in W_WAIT_W and R_DATA → all VALIDs are 0 and registers are 0 after the reset edge. The READY signals return to 1 one cycle after deassertion.
